rd_bus_sync: RTL and testbench
==============================

# rd_bus_sync

Parametrised, clock-synchronous successor to the MCU external-bus read multiplexer. It synchronises the asynchronous MCU read strobe and chip select into the system clock domain and decodes the address into a status byte or a byte of a multi-byte per-axis word. It drives the shared data bus. Reading byte 0 of an axis snapshots the whole axis word, so later bytes of the same word are coherent, and raises a per-axis read strobe for clear-on-read logic. It sits between the MCU bus pins and the N axis controllers.

## Interface
- `N_AXIS`, 8: number of axis channels, 1..(16-AXIS_BASE).
- `BYTES`, 4: bytes per axis word, 1..16.
- `XIN_BASE`, 4'h1: Addr[7:4] region of the Xin status byte.
- `AXIS_BASE`, 4'h3: Addr[7:4] region of axis 0. Axis k is at AXIS_BASE+k. Must not overlap XIN_BASE.
- `CLK` input 1: system clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `CS` input 1: MCU chip select, active low, asynchronous to CLK.
- `RD` input 1: MCU read strobe, active low, asynchronous to CLK.
- `Addr` input 8: MCU address. Stable from before the RD fall until after the RD rise.
- `Xin` input 8: live status byte.
- `AxisDQ` input N_AXIS*BYTES*8: live axis words. Axis k occupies bits [k*BYTES*8 +: BYTES*8]. Byte b of an axis is bits [b*8 +: 8] of that axis word.
- `DQ` output 8: tri-state data bus. Hi-Z when DQ_OE is 0.
- `DQ_OE` output 1: bus drive enable.
- `RdStrobe` output N_AXIS: one-CLK pulse on bit k when byte 0 of axis k is read.

## Operation
- Synchroniser: RD and CS each pass through two flops, giving rd_s and cs_s. Both reset to 1. A read start is rd_s=0 with the previous rd_s=1 while cs_s=0.
- States:
  - IDLE: go to LATCH on read start.
  - LATCH: exactly one cycle, then DRIVE.
  - DRIVE: stay while rd_s=0; go to IDLE when rd_s=1.
- LATCH cycle actions:
  - Capture Addr into addr_q.
  - Register the decoded byte into dq_q.
  - For an axis byte-0 access, also load that axis's snapshot register and pulse RdStrobe.
- Decode of region r=Addr[7:4] and byte index b=Addr[3:0]:
  - r==XIN_BASE: dq_q = Xin. b is ignored.
  - AXIS_BASE <= r < AXIS_BASE+N_AXIS, with k = r-AXIS_BASE:
    - b==0: snap[k] <= live word k. dq_q <= live byte 0. RdStrobe[k]=1 for the cycle after LATCH.
    - 0 < b < BYTES: dq_q = byte b of snap[k]. The live word is not used. snap[k] is unchanged.
    - b >= BYTES: dq_q = 8'h00. No strobe.
  - Any other region: dq_q = 8'h00. No strobe.
- Output drive: DQ_OE = (state==DRIVE) & ~RD & ~CS, using raw pins, so the bus is released combinationally on RD rise or CS rise. DQ = DQ_OE ? dq_q : 8'hzz.
- Storage: N_AXIS snapshot registers of BYTES*8 bits each. All reset to 0.

## Timing
- Reset values:
  - state IDLE; sync flops 1; addr_q, dq_q, all snap 0.
  - RdStrobe 0; DQ_OE 0; DQ Hi-Z.
  - Reset is asynchronous and takes effect mid-read: DQ goes Hi-Z immediately and any pending strobe is lost.
- Latency from RD fall:
  - rd_s is low after 2 or 3 CLK edges, depending on phase.
  - LATCH on the next edge; DRIVE and valid DQ on the following edge.
  - DQ is valid within 5 CLK periods of the RD fall. The MCU must hold RD low for at least 6 CLK periods before sampling.
- RdStrobe is high for exactly one cycle: the first DRIVE cycle.
- Early RD release (RD rises before DRIVE):
  - If the low was seen by rd_s, the FSM still runs LATCH and DRIVE, then IDLE. Snapshot and strobe still occur. DQ is never driven because the raw RD is high.
  - A low pulse not seen by rd_s has no effect.
- CS rising while RD is low: DQ_OE drops combinationally. The FSM returns to IDLE on the rd_s rise.
- Back-to-back reads need rd_s to return to 1 (back to IDLE) before the next read start. A continuously low RD produces exactly one access.
- Live AxisDQ changing during a multi-byte read does not affect bytes 1..BYTES-1.

## Test plan
- Xin read: Xin=8'hA5, Addr=8'h10, RD low for 8 CLK -> DQ=8'hA5 within 5 CLK and held while RD is low. Hi-Z after the RD rise. RdStrobe stays 0.
- Coherent multi-byte read: axis 2 live word 32'h11223344. Read Addr=8'h50 -> 8'h44 and RdStrobe[2] pulses one cycle. Then change live word 2 to 32'hFFFFFFFF. Read 8'h51/52/53 -> 8'h33, 8'h22, 8'h11, with no strobe.
- Out-of-range accesses: Addr=8'h54 (b>=BYTES), Addr=8'hB0 (region past axis 7), Addr=8'h20 (unmapped) -> DQ=8'h00, no strobe.
- Bus release: during DRIVE, raise CS while RD stays low -> DQ_OE=0 combinationally. FSM returns to IDLE after the RD rise.
- Reset mid-read: assert RST during DRIVE -> DQ Hi-Z at once, snap cleared. A following read of Addr=8'h31 returns 8'h00.
- Short RD glitch of 1 CLK aligned away from the edge -> no access. A 3 CLK low pulse -> strobe occurs and DQ is never driven.

Source files
------------

// File: rtl/rd_bus_sync.sv
// MCU external-bus read multiplexer: synchronises RD/CS into CLK and decodes Addr into a status byte
// or one byte of a per-axis word. A byte-0 read snapshots that whole axis word.
module rd_bus_sync #(
  parameter int         N_AXIS    = 8,
  parameter int         BYTES     = 4,
  parameter logic [3:0] XIN_BASE  = 4'h1,
  parameter logic [3:0] AXIS_BASE = 4'h3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CS,
  input  logic                       RD,
  input  logic [7:0]                 Addr,
  input  logic [7:0]                 Xin,
  input  logic [N_AXIS*BYTES*8-1:0]  AxisDQ,
  output tri   [7:0]                 DQ,
  output logic                       DQ_OE,
  output logic [N_AXIS-1:0]          RdStrobe
);

  localparam int WORD_W = BYTES * 8;

  typedef enum logic [1:0] {IDLE, LATCH, DRIVE} state_t;

  state_t state, state_next;

  logic rd_m, rd_s, rd_prev;
  logic cs_m, cs_s;
  logic read_start;

  logic [7:0] addr_q;
  logic [7:0] dq_q;
  logic [7:0] dq_next;
  logic       latched_q;

  logic [N_AXIS-1:0][WORD_W-1:0] snap;
  logic [N_AXIS-1:0]             axis_sel;
  logic [N_AXIS-1:0]             snap_load;
  logic [N_AXIS-1:0]             strobe_sel;

  logic [3:0]        region;
  logic [3:0]        byte_idx;
  logic              axis_hit;
  logic              byte0;
  logic [WORD_W-1:0] live_word;
  logic [WORD_W-1:0] snap_word;

  // Two-flop synchronisers plus one extra rd stage for falling-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_m    <= 1'b1;
      rd_s    <= 1'b1;
      rd_prev <= 1'b1;
      cs_m    <= 1'b1;
      cs_s    <= 1'b1;
    end else begin
      rd_m    <= RD;
      rd_s    <= rd_m;
      rd_prev <= rd_s;
      cs_m    <= CS;
      cs_s    <= cs_m;
    end
  end

  assign read_start = ~rd_s & rd_prev & ~cs_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (read_start) state_next = LATCH;
      LATCH:   state_next = DRIVE;
      DRIVE:   if (rd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign region   = Addr[7:4];
  assign byte_idx = Addr[3:0];
  assign byte0    = (byte_idx == 4'h0);
  assign axis_hit = |axis_sel;

  generate
    for (genvar gi = 0; gi < N_AXIS; gi++) begin : g_axis
      localparam logic [3:0] REGION_K = 4'(int'(AXIS_BASE) + gi);

      assign axis_sel[gi]   = (region == REGION_K);
      assign snap_load[gi]  = (state == LATCH) & axis_sel[gi] & byte0;
      // The strobe is decoded from the captured address so it lands in the first DRIVE cycle.
      assign strobe_sel[gi] = latched_q & (addr_q[7:4] == REGION_K) & (addr_q[3:0] == 4'h0);

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          snap[gi] <= '0;
        end else if (snap_load[gi]) begin
          snap[gi] <= AxisDQ[gi*WORD_W +: WORD_W];
        end
      end
    end
  endgenerate

  always_comb begin
    live_word = '0;
    snap_word = '0;
    for (int k = 0; k < N_AXIS; k++) begin
      if (axis_sel[k]) begin
        live_word = AxisDQ[k*WORD_W +: WORD_W];
        snap_word = snap[k];
      end
    end
  end

  // Bytes above 0 come only from the snapshot; indices at or past BYTES fall through to zero.
  always_comb begin
    dq_next = 8'h00;
    if (region == XIN_BASE) begin
      dq_next = Xin;
    end else if (axis_hit) begin
      if (byte0) begin
        dq_next = live_word[7:0];
      end else begin
        for (int b = 1; b < BYTES; b++) begin
          if (byte_idx == 4'(b)) begin
            dq_next = snap_word[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q    <= 8'h00;
      dq_q      <= 8'h00;
      latched_q <= 1'b0;
    end else begin
      latched_q <= (state == LATCH);
      if (state == LATCH) begin
        addr_q <= Addr;
        dq_q   <= dq_next;
      end
    end
  end

  assign RdStrobe = strobe_sel;

  // Raw pins gate the drive so the bus is released without waiting for the synchronisers.
  assign DQ_OE = (state == DRIVE) & ~RD & ~CS;
  assign DQ    = DQ_OE ? dq_q : 8'hzz;

endmodule

// File: tb/tb_rd_bus_sync.sv
// Directed bench for rd_bus_sync: address-level read model with per-cycle bus/strobe checks.
module tb_rd_bus_sync;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs;
  logic         rd;
  logic [7:0]   addr;
  logic [7:0]   xin;
  logic [255:0] axis_dq;
  wire  [7:0]   dq;
  logic         dq_oe;
  logic [7:0]   rd_strobe;

  always #5 clk = ~clk;

  rd_bus_sync #(
    .N_AXIS(8), .BYTES(4), .XIN_BASE(4'h1), .AXIS_BASE(4'h3)
  ) dut (
    .CLK(clk), .RST(rst), .CS(cs), .RD(rd), .Addr(addr), .Xin(xin),
    .AxisDQ(axis_dq), .DQ(dq), .DQ_OE(dq_oe), .RdStrobe(rd_strobe)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_dq;
  logic [7:0]  exp_mask;
  logic [31:0] model_snap [8];

  int         since_fall;
  int         oe_lat;
  int         oe_cyc;
  int         strobe_cnt;
  bit         oe_seen;
  logic [7:0] strobe_or;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic clear_track();
    since_fall = 0;
    oe_lat     = 0;
    oe_cyc     = 0;
    oe_seen    = 0;
    strobe_cnt = 0;
    strobe_or  = 8'h00;
  endtask

  // Advance one cycle and check the outputs at the falling edge.
  task automatic tick();
    @(negedge clk);
    if (!rd) since_fall++;
    check("oe_only_when_pins_low", 32'(dq_oe && (rd || cs)), 32'd0);
    if (dq_oe) begin
      check("dq_value", 32'(dq), 32'(exp_dq));
      oe_cyc++;
      if (!oe_seen) begin
        oe_seen = 1;
        oe_lat  = since_fall;
      end
    end else if (oe_seen && !rd && !cs && !rst) begin
      check("oe_held", 32'(dq_oe), 32'd1);
    end
    check("strobe_mask", 32'(rd_strobe & ~exp_mask), 32'd0);
    if (rd_strobe != 8'h00) strobe_cnt++;
    strobe_or |= rd_strobe;
  endtask

  // Read semantics from the address map: region, byte index, snapshot on byte 0.
  task automatic model_read(input logic [7:0] a, output logic [7:0] d, output logic [7:0] m);
    int r, b, k;
    r = int'(a[7:4]);
    b = int'(a[3:0]);
    d = 8'h00;
    m = 8'h00;
    if (r == 1) begin
      d = xin;
    end else if (r >= 3 && r < 11) begin
      k = r - 3;
      if (b == 0) begin
        model_snap[k] = axis_dq[k*32 +: 32];
        d = model_snap[k][7:0];
        m = 8'(1 << k);
      end else if (b < 4) begin
        d = model_snap[k][b*8 +: 8];
      end
    end
  endtask

  task automatic read_txn(input logic [7:0] a, input int n, input bit exp_oe,
                          input logic [7:0] lit_d, input logic [7:0] lit_m, input string name);
    logic [7:0] md, mm;
    model_read(a, md, mm);
    check({name, "_model_pin"}, {16'h0, md, mm}, {16'h0, lit_d, lit_m});
    addr     = a;
    exp_dq   = md;
    exp_mask = mm;
    clear_track();
    rd = 1'b0;
    repeat (n) tick();
    rd = 1'b1;
    #1 check({name, "_release"}, 32'(dq_oe), 32'd0);
    repeat (6) tick();
    exp_mask = 8'h00;
    if (exp_oe) begin
      check({name, "_driven"}, 32'(oe_seen), 32'd1);
      check({name, "_latency_le5"}, 32'(oe_lat <= 5), 32'd1);
    end else begin
      check({name, "_not_driven"}, 32'(oe_seen), 32'd0);
    end
    check({name, "_strobe_cycles"}, 32'(strobe_cnt), (mm != 8'h00) ? 32'd1 : 32'd0);
    check({name, "_strobe_bits"}, 32'(strobe_or), 32'(mm));
    $display("[TB] read %-16s addr=%h exp_dq=%h exp_strobe=%h oe_lat=%0d oe_cycles=%0d strobe=%h",
             name, a, md, mm, oe_lat, oe_cyc, strobe_or);
  endtask

  initial begin
    logic [7:0] md, mm;
    rst = 1'b1; rd = 1'b1; cs = 1'b1; addr = 8'h00; xin = 8'hA5; axis_dq = '0;
    exp_dq = 8'h00; exp_mask = 8'h00;
    for (int k = 0; k < 8; k++) model_snap[k] = 32'h0;
    clear_track();

    repeat (3) tick();
    check("reset_oe", 32'(dq_oe), 32'd0);
    check("reset_strobe", 32'(rd_strobe), 32'd0);
    rst = 1'b0;
    cs  = 1'b0;
    repeat (4) tick();
    check("idle_oe", 32'(dq_oe), 32'd0);

    read_txn(8'h10, 8, 1, 8'hA5, 8'h00, "xin");
    xin = 8'h3C;
    read_txn(8'h1F, 8, 1, 8'h3C, 8'h00, "xin_b_ignored");

    axis_dq[2*32 +: 32] = 32'h11223344;
    read_txn(8'h50, 8, 1, 8'h44, 8'h04, "ax2_b0");
    axis_dq[2*32 +: 32] = 32'hFFFFFFFF;
    read_txn(8'h51, 8, 1, 8'h33, 8'h00, "ax2_b1");
    read_txn(8'h52, 8, 1, 8'h22, 8'h00, "ax2_b2");
    read_txn(8'h53, 8, 1, 8'h11, 8'h00, "ax2_b3");

    read_txn(8'h54, 8, 1, 8'h00, 8'h00, "b_ge_bytes");
    read_txn(8'hB0, 8, 1, 8'h00, 8'h00, "past_axis7");
    read_txn(8'h20, 8, 1, 8'h00, 8'h00, "unmapped");

    // CS rises during DRIVE while RD stays low.
    model_read(8'h10, md, mm);
    addr = 8'h10; exp_dq = md; exp_mask = mm;
    clear_track();
    rd = 1'b0;
    for (int i = 0; i < 8 && !oe_seen; i++) tick();
    check("busrel_driven", 32'(oe_seen), 32'd1);
    cs = 1'b1;
    #1 check("busrel_cs_release", 32'(dq_oe), 32'd0);
    repeat (3) tick();
    rd = 1'b1;
    repeat (4) tick();
    cs = 1'b0;
    repeat (4) tick();
    $display("[TB] busrel addr=10 driven=%0d oe_after_cs=%0d", oe_seen, dq_oe);
    read_txn(8'h10, 8, 1, 8'h3C, 8'h00, "after_busrel");

    axis_dq[0 +: 32] = 32'hDEADBEEF;
    read_txn(8'h30, 8, 1, 8'hEF, 8'h01, "ax0_b0");
    read_txn(8'h31, 8, 1, 8'hBE, 8'h00, "ax0_b1");

    // Reset asserted in the middle of a driven read.
    model_read(8'h52, md, mm);
    addr = 8'h52; exp_dq = md; exp_mask = mm;
    clear_track();
    rd = 1'b0;
    for (int i = 0; i < 8 && !oe_seen; i++) tick();
    check("rst_mid_driven", 32'(oe_seen), 32'd1);
    rst = 1'b1;
    #1 check("rst_mid_hiz", 32'(dq_oe), 32'd0);
    rd = 1'b1;
    for (int k = 0; k < 8; k++) model_snap[k] = 32'h0;
    repeat (2) tick();
    check("rst_mid_strobe", 32'(rd_strobe), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    $display("[TB] reset_mid_read addr=52 oe_after_rst=%0d", dq_oe);
    read_txn(8'h31, 8, 1, 8'h00, 8'h00, "ax0_b1_cleared");
    read_txn(8'h51, 8, 1, 8'h00, 8'h00, "ax2_b1_cleared");

    // Low glitch entirely between two rising edges.
    axis_dq[0 +: 32] = 32'hCAFE0102;
    addr = 8'h30; exp_mask = 8'h00;
    clear_track();
    #1 rd = 1'b0;
    #3 rd = 1'b1;
    repeat (6) tick();
    check("glitch_no_strobe", 32'(strobe_cnt), 32'd0);
    check("glitch_not_driven", 32'(oe_seen), 32'd0);
    $display("[TB] glitch addr=30 strobe_cycles=%0d driven=%0d", strobe_cnt, oe_seen);
    read_txn(8'h31, 8, 1, 8'h00, 8'h00, "after_glitch");

    read_txn(8'h30, 3, 0, 8'h02, 8'h01, "short_pulse");
    read_txn(8'h31, 8, 1, 8'h01, 8'h00, "after_short");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
